swap_capture: RTL and testbench
===============================

SWAP_CAPTURE -- requirements
Module: swap_capture

Interface
REQ-001 Parameter LOCK_CNT, default 4: number of consecutive consistent samples, including the first, required to declare lock; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 s_valid  input  1  a sample is present on s_a/s_b this cycle; there is no input backpressure.
REQ-005 s_a, s_b  input  1 each  lane pair from an alternating swap register; each new sample is expected to be the previous pair swapped.
REQ-006 m_valid  output  1  recovered pair available.
REQ-007 m_ready  input  1  consumer accepts the beat when m_valid and m_ready are both 1.
REQ-008 m_a, m_b  output  1 each  recovered original pair.
REQ-009 lock_o  output  1  stream is locked.
REQ-010 phase_o  output  1  0 when the last sample equals the reference pair; 1 when it is swapped.
REQ-011 err_o  output  1  one-cycle pulse on a consistency violation.
REQ-012 ovf_o  output  1  one-cycle pulse when an unconsumed beat is overwritten.

Function
REQ-013 A sample is consistent when (s_a,s_b) == (prev_b,prev_a); a pair with a==b is therefore consistent with itself.
REQ-014 States: IDLE, ACQUIRE, LOCKED, ERROR; s_valid=0 leaves all state, counters and outputs unchanged.
REQ-015 IDLE or ERROR, valid sample -> ACQUIRE; ref=prev=sample; match_cnt=1; phase=0.
REQ-016 ACQUIRE, consistent sample -> match_cnt+1 and phase toggles; at match_cnt==LOCK_CNT go to LOCKED.
REQ-017 ACQUIRE, inconsistent sample -> err_o pulses; the sample restarts acquisition as in REQ-015.
REQ-018 LOCKED, consistent sample -> stay in LOCKED; phase toggles.
REQ-019 LOCKED, inconsistent sample -> ERROR; err_o pulses; lock_o falls the next cycle.
REQ-020 On entry to LOCKED, load one beat: m_a/m_b = ref pair (un-swapped); m_valid=1.
REQ-021 A beat is held stable until handshake; m_valid clears on the handshake edge.
REQ-022 New beat while one is pending and m_ready=0 -> the new beat overwrites it and ovf_o pulses.
REQ-023 New beat while one is pending and m_ready=1 -> the old beat is consumed, the new beat loads, and ovf_o stays 0.
REQ-024 All outputs are registered; lock_o, phase_o and err_o reflect the sample accepted on the previous edge (latency 1).

Reset
REQ-025 While rst=1: state=IDLE; match_cnt, ref and prev = 0; all outputs = 0.
REQ-026 Reset mid-operation discards any pending beat and acquisition progress without emitting err_o or ovf_o.

Configuration
REQ-027 With SWAP_CAPTURE_ERRCNT_EN defined: add output err_cnt_o, 8 bits wide, which increments on each err_o pulse, saturates at 255, and is cleared by rst.
REQ-028 Without SWAP_CAPTURE_ERRCNT_EN: the err_cnt_o port and its counter do not exist; all other behaviour is identical.

Structure
REQ-029 Shared package swap_pkg holds the state enumeration, the LOCK_CNT default, and the match counter width constant (4).
REQ-030 The one-entry output holding register (m_valid, m_a, m_b, overwrite/ovf logic) is sub-module swap_capture_oreg; the FSM stays in swap_capture.

Verification
REQ-031 Reset, then samples (1,0),(0,1),(1,0),(0,1) -> after 4th edge: lock_o=1, phase_o=1, m_valid=1, m_a=1, m_b=0.
REQ-032 Locked with expected next (1,0), drive (1,1) -> err_o=1 for one cycle, lock_o=0; then (0,1) -> ACQUIRE, match_cnt=1, no err_o.
REQ-033 ACQUIRE with s_valid=0 for 3 cycles after 2nd sample -> no change; lock after 4th valid sample.
REQ-034 m_ready=0; lock; error; relock on (0,1) start -> ovf_o pulses once, m_a=0, m_b=1; m_ready=1 -> m_valid=0 next cycle.
REQ-035 Constant (1,1) for 4 samples -> lock_o=1, m_a=1, m_b=1, err_o never asserted.
REQ-036 rst=1 for one cycle while locked with a pending beat -> next cycle all outputs 0, state IDLE; with SWAP_CAPTURE_ERRCNT_EN, err_cnt_o=0.

Source files
------------

// File: rtl/swap_pkg.sv
// swap_pkg: shared state encoding and sizing constants for swap_capture.
package swap_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED, ST_ERROR} state_t;
    localparam int LOCK_CNT_DEF = 4;
    localparam int CNT_W = 4;
endpackage

// File: rtl/swap_capture_oreg.sv
// swap_capture_oreg: one-entry output holding register with overwrite detection.
module swap_capture_oreg (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_a,
    input  logic i_b,
    input  logic i_ready,
    output logic o_valid,
    output logic o_a,
    output logic o_b,
    output logic o_ovf
);
    logic r_valid, r_a, r_b, r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // a pending beat is lost only if nobody takes it on the same edge
            r_ovf <= i_load & r_valid & ~i_ready;
            if (i_load) begin
                r_valid <= 1'b1;
                r_a     <= i_a;
                r_b     <= i_b;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_ovf   = r_ovf;
endmodule

// File: rtl/swap_capture.sv
// swap_capture: locks onto an alternating swapped lane pair and recovers the original pair.
// Optional SWAP_CAPTURE_ERRCNT_EN adds a saturating 8-bit error counter output err_cnt_o.
module swap_capture
    import swap_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic       s_a,
    input  logic       s_b,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_a,
    output logic       m_b,
    output logic       lock_o,
    output logic       phase_o,
    output logic       err_o,
`ifdef SWAP_CAPTURE_ERRCNT_EN
    output logic [7:0] err_cnt_o,
`endif
    output logic       ovf_o
);
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic             r_ref_a, r_ref_b, r_prev_a, r_prev_b, r_phase, r_lock, r_err;
    logic             w_ref_a_nx, w_ref_b_nx, w_prev_a_nx, w_prev_b_nx, w_phase_nx, w_err_nx;
    logic             w_cons, w_load;

    assign w_cons    = (s_a == r_prev_b) && (s_b == r_prev_a);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_ref_a_nx  = r_ref_a;
        w_ref_b_nx  = r_ref_b;
        w_prev_a_nx = r_prev_a;
        w_prev_b_nx = r_prev_b;
        w_phase_nx  = r_phase;
        w_err_nx    = 1'b0;
        w_load      = 1'b0;
        if (s_valid) begin
            w_prev_a_nx = s_a;
            w_prev_b_nx = s_b;
            if (r_state == ST_ACQUIRE && w_cons) begin
                w_cnt_nx   = w_cnt_inc;
                w_phase_nx = ~r_phase;
                if (w_cnt_inc == CNT_W'(LOCK_CNT)) begin
                    w_state_nx = ST_LOCKED;
                    w_load     = 1'b1;
                end
            end else if (r_state == ST_LOCKED) begin
                w_phase_nx = w_cons ? ~r_phase : r_phase;
                w_state_nx = w_cons ? ST_LOCKED : ST_ERROR;
                w_err_nx   = ~w_cons;
            end else begin
                // idle, error, or a broken acquisition: this sample becomes the new reference
                w_err_nx   = (r_state == ST_ACQUIRE);
                w_state_nx = ST_ACQUIRE;
                w_ref_a_nx = s_a;
                w_ref_b_nx = s_b;
                w_cnt_nx   = CNT_W'(1);
                w_phase_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ref_a  <= 1'b0;
            r_ref_b  <= 1'b0;
            r_prev_a <= 1'b0;
            r_prev_b <= 1'b0;
            r_phase  <= 1'b0;
            r_lock   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_ref_a  <= w_ref_a_nx;
            r_ref_b  <= w_ref_b_nx;
            r_prev_a <= w_prev_a_nx;
            r_prev_b <= w_prev_b_nx;
            r_phase  <= w_phase_nx;
            r_lock   <= (w_state_nx == ST_LOCKED);
            r_err    <= w_err_nx;
        end
    end

`ifdef SWAP_CAPTURE_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= '0;
        else if (w_err_nx && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt_o = r_err_cnt;
`endif

    swap_capture_oreg u_oreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_a     (r_ref_a),
        .i_b     (r_ref_b),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_a     (m_a),
        .o_b     (m_b),
        .o_ovf   (ovf_o)
    );

    assign lock_o  = r_lock;
    assign phase_o = r_phase;
    assign err_o   = r_err;
endmodule

// File: tb/tb_swap_capture.sv
// tb_swap_capture: scoreboard bench for swap_capture with a run-length reference model.
module tb_swap_capture;
    localparam int LOCK_CNT = 4;

    logic clk = 1'b0;
    logic rst, s_valid, s_a, s_b, m_ready;
    logic m_valid, m_a, m_b, lock_o, phase_o, err_o, ovf_o;
`ifdef SWAP_CAPTURE_ERRCNT_EN
    logic [7:0] err_cnt_o;
`endif

    swap_capture #(.LOCK_CNT(LOCK_CNT)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_a     (s_a),
        .s_b     (s_b),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_a     (m_a),
        .m_b     (m_b),
        .lock_o  (lock_o),
        .phase_o (phase_o),
        .err_o   (err_o),
`ifdef SWAP_CAPTURE_ERRCNT_EN
        .err_cnt_o (err_cnt_o),
`endif
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic lock, ph, err, ovf, mv, ma, mb;
        logic [7:0] ecnt;
    } st_t;

    st_t        exp_q[$];
    logic [1:0] beat_q[$];
    int n_chk = 0, n_fail = 0;

    // reference model: run = consecutive consistent samples so far (0 = no reference yet)
    int   run, ecnt;
    logic locked, pa, pb, ra, rb, ph, pend, ba, bb;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic a, input logic b,
                              input logic rdy, input logic r);
        logic err, ovf, load, pend_pre;
        st_t  e;
        err = 0; ovf = 0; load = 0; pend_pre = pend;
        if (r) begin
            run = 0; locked = 0; pa = 0; pb = 0; ra = 0; rb = 0; ph = 0;
            pend = 0; ba = 0; bb = 0; ecnt = 0;
            beat_q.delete();
        end else begin
            if (v) begin
                if (run != 0 && a == pb && b == pa) begin
                    ph = ~ph;
                    if (!locked) begin
                        run++;
                        if (run == LOCK_CNT) begin
                            locked = 1;
                            load = 1;
                        end
                    end
                end else if (locked) begin
                    err = 1; locked = 0; run = 0;
                end else begin
                    err = (run != 0);
                    run = 1; ra = a; rb = b; ph = 0;
                end
                pa = a; pb = b;
            end
            if (load) begin
                if (pend_pre && !rdy) begin
                    ovf = 1;
                    void'(beat_q.pop_back());
                end
                beat_q.push_back({ra, rb});
                pend = 1; ba = ra; bb = rb;
            end else if (pend_pre && rdy) begin
                pend = 0;
            end
            if (err && ecnt < 255) ecnt++;
        end
        e.lock = locked; e.ph = ph; e.err = err; e.ovf = ovf;
        e.mv = pend; e.ma = ba; e.mb = bb; e.ecnt = 8'(ecnt);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic a, input logic b,
                        input logic rdy, input logic r);
        rst = r; s_valid = v; s_a = a; s_b = b; m_ready = rdy;
        model_edge(v, a, b, rdy, r);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        st_t        e;
        logic [1:0] bt;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("lock_o", 8'(lock_o), 8'(e.lock));
            chk("phase_o", 8'(phase_o), 8'(e.ph));
            chk("err_o", 8'(err_o), 8'(e.err));
            chk("ovf_o", 8'(ovf_o), 8'(e.ovf));
            chk("m_valid", 8'(m_valid), 8'(e.mv));
            chk("m_pair", 8'({m_a, m_b}), 8'({e.ma, e.mb}));
`ifdef SWAP_CAPTURE_ERRCNT_EN
            chk("err_cnt_o", err_cnt_o, e.ecnt);
`endif
        end
        if (!rst && m_valid && m_ready) begin
            if (beat_q.size() == 0) begin
                chk("beat_unexpected", 8'({m_a, m_b}), 8'hEE);
            end else begin
                bt = beat_q.pop_front();
                chk("beat_handshake", 8'({m_a, m_b}), 8'(bt));
            end
        end
    end

    initial begin
        logic tpa, tpb, v, a, b;
        tpa = 0; tpb = 0;
        step(0, 0, 0, 0, 1);
        chk("reset_outputs", 8'({lock_o, phase_o, err_o, ovf_o, m_valid, m_a, m_b}), 8'h00);
        step(0, 0, 0, 0, 0);
        // basic lock
        step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 1, 0, 0, 0);
        chk("no_lock_early", 8'(lock_o), 8'h0);
        step(1, 0, 1, 0, 0);
        chk("lock_basic", 8'({lock_o, phase_o, m_valid, m_a, m_b}), 8'b11110);
        // violation while locked, then restart
        step(1, 1, 1, 0, 0);
        chk("lock_violation", 8'({err_o, lock_o}), 8'b10);
        step(1, 0, 1, 0, 0);
        chk("restart_no_err", 8'({err_o, lock_o, phase_o}), 8'b000);
        // relock with old beat pending -> overwrite
        step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0); step(1, 1, 0, 0, 0);
        chk("relock_ovf", 8'({ovf_o, m_valid, m_a, m_b}), 8'b1101);
        step(0, 0, 0, 1, 0);
        chk("ovf_one_pulse", 8'({ovf_o, m_valid}), 8'b00);
        // idle gaps during acquisition
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0); step(1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        chk("gap_hold", 8'({lock_o, phase_o, err_o}), 8'b010);
        step(1, 1, 0, 0, 0);
        chk("gap_not_locked", 8'(lock_o), 8'h0);
        step(1, 0, 1, 0, 0);
        chk("gap_lock", 8'({lock_o, m_a, m_b}), 8'b110);
        // constant (1,1) stream
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
        chk("const_11", 8'({lock_o, err_o, m_valid, m_a, m_b}), 8'b10111);
        // reset with pending beat
        step(0, 0, 0, 0, 1);
        chk("reset_pending", 8'({lock_o, phase_o, err_o, ovf_o, m_valid, m_a, m_b}), 8'h00);
`ifdef SWAP_CAPTURE_ERRCNT_EN
        chk("reset_errcnt", err_cnt_o, 8'h00);
`endif
        // randomized mostly-consistent traffic
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(3) != 0);
            if ($urandom_range(9) != 0) begin a = tpb; b = tpa; end
            else begin a = 1'($urandom); b = 1'($urandom); end
            if (v) begin tpa = a; tpb = b; end
            step(v, a, b, 1'($urandom), $urandom_range(199) == 0);
        end
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 8'(exp_q.size()), 8'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
